// File: rtl/flags_stack_register.sv
// Status-flags register with per-bit masked update and a LIFO save/restore
// stack for interrupt/call context; flags output lags the live register by one edge.
module flags_stack_register #(
    parameter int                FLAG_W      = 4,
    parameter int                DEPTH       = 4,
    parameter logic [FLAG_W-1:0] RESET_FLAGS = '0
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET,
    input  logic [FLAG_W-1:0]            NZCV,
    input  logic                         CNTRL_update_en,
    input  logic [FLAG_W-1:0]            CNTRL_update_mask,
    input  logic                         CNTRL_push,
    input  logic                         CNTRL_pop,
    input  logic                         CNTRL_err_clr,
    output logic [FLAG_W-1:0]            flags,
    output logic [$clog2(DEPTH+1)-1:0]   stack_count,
    output logic                         stack_full,
    output logic                         stack_empty,
    output logic                         stack_ovf,
    output logic                         stack_unf
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FLAG_W-1:0] live;
    logic [FLAG_W-1:0] live_nxt;
    logic [FLAG_W-1:0] upd_val;
    logic [FLAG_W-1:0] stack_mem [DEPTH];
    logic [CNT_W-1:0]  count_nxt;
    logic [IDX_W-1:0]  top_idx;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_en;
    logic              ovf_set;
    logic              unf_set;

    assign stack_full  = (stack_count == CNT_W'(DEPTH));
    assign stack_empty = (stack_count == '0);
    assign top_idx     = IDX_W'(stack_count - 1'b1);
    assign upd_val     = (live & ~CNTRL_update_mask) | (NZCV & CNTRL_update_mask);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        live_nxt  = CNTRL_update_en ? upd_val : live;
        count_nxt = stack_count;
        wr_en     = 1'b0;
        wr_idx    = top_idx;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;

        if (CNTRL_push && CNTRL_pop && !stack_empty) begin
            // Exchange: top and live swap places, update is dropped.
            wr_en    = 1'b1;
            live_nxt = stack_mem[top_idx];
        end else if (CNTRL_push) begin
            if (stack_full) begin
                ovf_set = 1'b1;
            end else begin
                wr_en     = 1'b1;
                wr_idx    = IDX_W'(stack_count);
                count_nxt = stack_count + 1'b1;
            end
        end else if (CNTRL_pop) begin
            if (stack_empty) begin
                unf_set = 1'b1;
            end else begin
                live_nxt  = stack_mem[top_idx];
                count_nxt = stack_count - 1'b1;
            end
        end
    end

    // NOTE: stack contents carry no reset; only the count decides which entries are valid.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en && !RESET)
            stack_mem[wr_idx] <= live;
    end

    // NOTE: non-blocking assignments so flags samples the old live value on the same edge.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            live        <= RESET_FLAGS;
            flags       <= RESET_FLAGS;
            stack_count <= '0;
            stack_ovf   <= 1'b0;
            stack_unf   <= 1'b0;
        end else begin
            live        <= live_nxt;
            flags       <= live;
            stack_count <= count_nxt;

            if (ovf_set)
                stack_ovf <= 1'b1;
            else if (CNTRL_err_clr)
                stack_ovf <= 1'b0;

            if (unf_set)
                stack_unf <= 1'b1;
            else if (CNTRL_err_clr)
                stack_unf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flags_stack_register.sv
// Directed-vector bench for flags_stack_register: a DEPTH=4 instance for the
// main sequence and a DEPTH=1 instance sharing the same stimulus.
module tb_flags_stack_register;

    logic       CLOCK_50 = 1'b0;
    logic       RESET;
    logic [3:0] NZCV;
    logic       CNTRL_update_en;
    logic [3:0] CNTRL_update_mask;
    logic       CNTRL_push;
    logic       CNTRL_pop;
    logic       CNTRL_err_clr;

    logic [3:0] flags;
    logic [2:0] stack_count;
    logic       stack_full, stack_empty, stack_ovf, stack_unf;

    logic [3:0] flags1;
    logic [0:0] stack_count1;
    logic       stack_full1, stack_empty1, stack_ovf1, stack_unf1;

    int vectors     = 0;
    int miscompares = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    flags_stack_register #(.FLAG_W(4), .DEPTH(4), .RESET_FLAGS(4'b0000)) u_dut (
        .CLOCK_50          (CLOCK_50),
        .RESET             (RESET),
        .NZCV              (NZCV),
        .CNTRL_update_en   (CNTRL_update_en),
        .CNTRL_update_mask (CNTRL_update_mask),
        .CNTRL_push        (CNTRL_push),
        .CNTRL_pop         (CNTRL_pop),
        .CNTRL_err_clr     (CNTRL_err_clr),
        .flags             (flags),
        .stack_count       (stack_count),
        .stack_full        (stack_full),
        .stack_empty       (stack_empty),
        .stack_ovf         (stack_ovf),
        .stack_unf         (stack_unf)
    );

    flags_stack_register #(.FLAG_W(4), .DEPTH(1), .RESET_FLAGS(4'b0000)) u_dut1 (
        .CLOCK_50          (CLOCK_50),
        .RESET             (RESET),
        .NZCV              (NZCV),
        .CNTRL_update_en   (CNTRL_update_en),
        .CNTRL_update_mask (CNTRL_update_mask),
        .CNTRL_push        (CNTRL_push),
        .CNTRL_pop         (CNTRL_pop),
        .CNTRL_err_clr     (CNTRL_err_clr),
        .flags             (flags1),
        .stack_count       (stack_count1),
        .stack_full        (stack_full1),
        .stack_empty       (stack_empty1),
        .stack_ovf         (stack_ovf1),
        .stack_unf         (stack_unf1)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of controls, clock it, then return inputs to idle.
    task automatic op(input logic ue, input logic [3:0] m, input logic [3:0] n,
                      input logic pu, input logic po, input logic ec);
        CNTRL_update_en   = ue;
        CNTRL_update_mask = m;
        NZCV              = n;
        CNTRL_push        = pu;
        CNTRL_pop         = po;
        CNTRL_err_clr     = ec;
        @(posedge CLOCK_50);
        #1;
        CNTRL_update_en   = 1'b0;
        CNTRL_update_mask = 4'h0;
        NZCV              = 4'h0;
        CNTRL_push        = 1'b0;
        CNTRL_pop         = 1'b0;
        CNTRL_err_clr     = 1'b0;
    endtask

    task automatic idle();
        op(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_live(input logic [3:0] v);
        op(1'b1, 4'hF, v, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        RESET             = 1'b1;
        NZCV              = 4'h0;
        CNTRL_update_en   = 1'b0;
        CNTRL_update_mask = 4'h0;
        CNTRL_push        = 1'b0;
        CNTRL_pop         = 1'b0;
        CNTRL_err_clr     = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        RESET = 1'b0;

        check("rst_flags", 8'(flags), 8'h0);
        check("rst_count", 8'(stack_count), 8'd0);
        check("rst_empty", 8'(stack_empty), 8'd1);
        check("rst_full",  8'(stack_full), 8'd0);
        check("rst_ovf",   8'(stack_ovf), 8'd0);
        check("rst_unf",   8'(stack_unf), 8'd0);

        // Masked update and two-edge latency
        op(1'b1, 4'b1010, 4'b1111, 1'b0, 1'b0, 1'b0);
        check("upd_lat_k", 8'(flags), 8'h0);
        idle();
        check("upd_lat_k1", 8'(flags), 8'b1010);
        op(1'b1, 4'b0000, 4'b0101, 1'b0, 1'b0, 1'b0);
        idle();
        check("upd_mask0", 8'(flags), 8'b1010);

        // Push/pop round trip
        set_live(4'b0110);
        op(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        check("rt_push_cnt", 8'(stack_count), 8'd1);
        set_live(4'b1001);
        idle();
        check("rt_upd", 8'(flags), 8'b1001);
        op(1'b1, 4'hF, 4'b1111, 1'b0, 1'b1, 1'b0);
        check("rt_pop_cnt", 8'(stack_count), 8'd0);
        check("rt_pop_lat", 8'(flags), 8'b1001);
        idle();
        check("rt_pop_val", 8'(flags), 8'b0110);

        // Fill to DEPTH, then overflow
        for (int i = 1; i <= 4; i++) begin
            set_live(4'(i));
            op(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        end
        check("full_cnt",  8'(stack_count), 8'd4);
        check("full_flag", 8'(stack_full), 8'd1);
        check("full_ovf0", 8'(stack_ovf), 8'd0);
        set_live(4'd5);
        op(1'b1, 4'hF, 4'd6, 1'b1, 1'b0, 1'b0);
        check("ovf_set", 8'(stack_ovf), 8'd1);
        check("ovf_cnt", 8'(stack_count), 8'd4);
        idle();
        check("ovf_upd", 8'(flags), 8'd6);
        op(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);
        check("ovf_set_wins", 8'(stack_ovf), 8'd1);
        for (int i = 4; i >= 1; i--) begin
            op(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
            idle();
            check($sformatf("pop_%0d", i), 8'(flags), 8'(i));
        end
        check("drain_empty", 8'(stack_empty), 8'd1);
        check("ovf_sticky", 8'(stack_ovf), 8'd1);
        op(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        check("ovf_clr", 8'(stack_ovf), 8'd0);

        // Underflow and clear
        op(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        check("unf_set", 8'(stack_unf), 8'd1);
        check("unf_cnt", 8'(stack_count), 8'd0);
        idle();
        check("unf_hold", 8'(flags), 8'd1);
        op(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        check("unf_set_wins", 8'(stack_unf), 8'd1);
        op(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        check("unf_clr", 8'(stack_unf), 8'd0);
        op(1'b1, 4'hF, 4'b0111, 1'b0, 1'b1, 1'b0);
        idle();
        check("unf_upd", 8'(flags), 8'b0111);
        check("unf_set2", 8'(stack_unf), 8'd1);
        op(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);

        // Exchange
        set_live(4'b0011);
        op(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        set_live(4'b1100);
        op(1'b1, 4'hF, 4'b1111, 1'b1, 1'b1, 1'b0);
        check("xchg_cnt", 8'(stack_count), 8'd1);
        idle();
        check("xchg_live", 8'(flags), 8'b0011);
        op(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        idle();
        check("xchg_top", 8'(flags), 8'b1100);
        check("xchg_empty", 8'(stack_empty), 8'd1);

        // Push+pop on empty stack behaves as push only
        op(1'b1, 4'hF, 4'b0101, 1'b1, 1'b1, 1'b0);
        check("pp_empty_cnt", 8'(stack_count), 8'd1);
        check("pp_empty_unf", 8'(stack_unf), 8'd0);
        idle();
        check("pp_empty_upd", 8'(flags), 8'b0101);
        op(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        idle();
        check("pp_empty_pop", 8'(flags), 8'b1100);

        // Asynchronous reset mid-cycle
        op(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        op(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        set_live(4'b1111);
        idle();
        check("pre_rst_flags", 8'(flags), 8'hF);
        check("pre_rst_unf", 8'(stack_unf), 8'd1);
        #5;
        RESET = 1'b1;
        #1;
        check("arst_flags", 8'(flags), 8'h0);
        check("arst_count", 8'(stack_count), 8'd0);
        check("arst_empty", 8'(stack_empty), 8'd1);
        check("arst_ovf",   8'(stack_ovf), 8'd0);
        check("arst_unf",   8'(stack_unf), 8'd0);
        CNTRL_push = 1'b1;
        @(posedge CLOCK_50);
        #1;
        CNTRL_push = 1'b0;
        check("rst_push_abort", 8'(stack_count), 8'd0);
        RESET = 1'b0;

        // DEPTH = 1 instance
        check("d1_empty", 8'(stack_empty1), 8'd1);
        check("d1_full0", 8'(stack_full1), 8'd0);
        set_live(4'b0011);
        op(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        check("d1_full", 8'(stack_full1), 8'd1);
        check("d1_nempty", 8'(stack_empty1), 8'd0);
        set_live(4'b1100);
        op(1'b1, 4'hF, 4'b1111, 1'b1, 1'b1, 1'b0);
        idle();
        check("d1_xchg", 8'(flags1), 8'b0011);
        op(1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        check("d1_ovf", 8'(stack_ovf1), 8'd1);
        op(1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        idle();
        check("d1_pop", 8'(flags1), 8'b1100);
        check("d1_empty2", 8'(stack_empty1), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
